// File: rtl/ctr_game_player.sv
`default_nettype none
// ============================================================================
//  Module      : ctr_game_player
//  Description : Player/referee for the counter-game interface. Drives the
//                counter's control code, init strobe and load value, counts
//                win/lose events per match, keeps match scoreboards and
//                raises sticky flags when the counter breaks the protocol.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctr_game_player #(
    parameter int GOAL    = 15,
    parameter int CNT_W   = 4,
    parameter int MATCH_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               use_init,
    input  logic [3:0]         start_value,
    input  logic [1:0]         strategy,
    input  logic [1:0]         fixed_control,
    input  logic               winner,
    input  logic               loser,
    input  logic               gameover,
    input  logic [1:0]         who,
    output logic [1:0]         control,
    output logic               init,
    output logic [3:0]         initial_value,
    output logic               busy,
    output logic [CNT_W-1:0]   win_events,
    output logic [CNT_W-1:0]   lose_events,
    output logic [MATCH_W-1:0] matches_won,
    output logic [MATCH_W-1:0] matches_lost,
    output logic               match_done,
    output logic               err_pulse,
    output logic               err_both,
    output logic               err_who
);

    // ------------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_PLAY  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [1:0] STRAT_FIXED = 2'b00;
    localparam logic [1:0] STRAT_UP2   = 2'b01;
    localparam logic [1:0] STRAT_DOWN2 = 2'b10;
    localparam logic [1:0] STRAT_RR    = 2'b11;

    localparam logic [1:0] CTRL_UP1   = 2'b00;
    localparam logic [1:0] CTRL_UP2   = 2'b01;
    localparam logic [1:0] CTRL_DOWN2 = 2'b11;

    localparam logic [1:0] WHO_LOSE = 2'b01;
    localparam logic [1:0] WHO_WIN  = 2'b10;

    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]   GOAL_C    = CNT_W'(GOAL);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);

    // ------------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------------
    logic [1:0]         state_q,        state_d;
    logic [1:0]         strategy_q,     strategy_d;
    logic [1:0]         rr_idx_q,       rr_idx_d;
    logic               stop_pending_q, stop_pending_d;
    logic               prev_winner_q,  prev_winner_d;
    logic               prev_loser_q,   prev_loser_d;

    logic [1:0]         control_q,       control_d;
    logic               init_q,          init_d;
    logic [3:0]         initial_value_q, initial_value_d;
    logic               busy_q,          busy_d;
    logic [CNT_W-1:0]   win_events_q,    win_events_d;
    logic [CNT_W-1:0]   lose_events_q,   lose_events_d;
    logic [MATCH_W-1:0] matches_won_q,   matches_won_d;
    logic [MATCH_W-1:0] matches_lost_q,  matches_lost_d;
    logic               match_done_q,    match_done_d;
    logic               err_pulse_q,     err_pulse_d;
    logic               err_both_q,      err_both_d;
    logic               err_who_q,       err_who_d;

    // Event counts including this cycle's pulses, saturating at the top.
    logic [CNT_W-1:0]   w_win_eff;
    logic [CNT_W-1:0]   w_lose_eff;
    logic               w_checking;
    logic               w_who_illegal;
    logic               w_stop_now;
    logic [1:0]         w_rr_cur;

    assign w_win_eff  = (winner && (win_events_q  != CNT_MAX)) ? win_events_q  + CNT_ONE
                                                               : win_events_q;
    assign w_lose_eff = (loser  && (lose_events_q != CNT_MAX)) ? lose_events_q + CNT_ONE
                                                               : lose_events_q;
    assign w_checking    = (state_q == S_PLAY) || (state_q == S_DRAIN);
    assign w_who_illegal = gameover && (who != WHO_WIN) && (who != WHO_LOSE);
    // A stop arriving during DRAIN itself still ends the session there.
    assign w_stop_now    = stop_pending_q || stop;
    // Round-robin restarts from code 00 on the first PLAY cycle after LOAD.
    assign w_rr_cur      = (state_q == S_LOAD) ? 2'd0 : rr_idx_q;

    // State register and every other flop, synchronous active-high reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_IDLE;
            strategy_q      <= 2'd0;
            rr_idx_q        <= 2'd0;
            stop_pending_q  <= 1'b0;
            prev_winner_q   <= 1'b0;
            prev_loser_q    <= 1'b0;
            control_q       <= 2'd0;
            init_q          <= 1'b0;
            initial_value_q <= 4'd0;
            busy_q          <= 1'b0;
            win_events_q    <= '0;
            lose_events_q   <= '0;
            matches_won_q   <= '0;
            matches_lost_q  <= '0;
            match_done_q    <= 1'b0;
            err_pulse_q     <= 1'b0;
            err_both_q      <= 1'b0;
            err_who_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            strategy_q      <= strategy_d;
            rr_idx_q        <= rr_idx_d;
            stop_pending_q  <= stop_pending_d;
            prev_winner_q   <= prev_winner_d;
            prev_loser_q    <= prev_loser_d;
            control_q       <= control_d;
            init_q          <= init_d;
            initial_value_q <= initial_value_d;
            busy_q          <= busy_d;
            win_events_q    <= win_events_d;
            lose_events_q   <= lose_events_d;
            matches_won_q   <= matches_won_d;
            matches_lost_q  <= matches_lost_d;
            match_done_q    <= match_done_d;
            err_pulse_q     <= err_pulse_d;
            err_both_q      <= err_both_d;
            err_who_q       <= err_who_d;
        end
    end

    // Next-state logic: session flow IDLE -> LOAD -> PLAY <-> DRAIN -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)    state_d = S_LOAD;
            S_LOAD:                state_d = S_PLAY;
            S_PLAY:  if (gameover) state_d = S_DRAIN;
            S_DRAIN: state_d = w_stop_now ? S_IDLE : S_PLAY;
            default:               state_d = S_IDLE;
        endcase
    end

    // Registered interface outputs, computed for the state being entered
    always_comb begin
        control_d       = CTRL_UP1;
        init_d          = 1'b0;
        initial_value_d = 4'd0;
        rr_idx_d        = rr_idx_q;
        busy_d          = (state_d != S_IDLE);

        if (state_d == S_LOAD) begin
            init_d          = use_init;
            initial_value_d = start_value;
        end

        if (state_d == S_PLAY) begin
            rr_idx_d = w_rr_cur + 2'd1;
            case (strategy_q)
                STRAT_FIXED: control_d = fixed_control;
                STRAT_UP2:   control_d = CTRL_UP2;
                STRAT_DOWN2: control_d = CTRL_DOWN2;
                STRAT_RR:    control_d = w_rr_cur;
                default:     control_d = CTRL_UP1;
            endcase
        end
    end

    // Session capture, stop tracking, event and match scoreboards
    always_comb begin
        strategy_d     = strategy_q;
        win_events_d   = win_events_q;
        lose_events_d  = lose_events_q;
        matches_won_d  = matches_won_q;
        matches_lost_d = matches_lost_q;
        match_done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    strategy_d    = strategy;
                    win_events_d  = '0;
                    lose_events_d = '0;
                end
            end
            S_PLAY: begin
                win_events_d  = w_win_eff;
                lose_events_d = w_lose_eff;
                if (gameover) begin
                    match_done_d = 1'b1;
                    if (who == WHO_WIN)  matches_won_d  = matches_won_q  + MATCH_ONE;
                    if (who == WHO_LOSE) matches_lost_d = matches_lost_q + MATCH_ONE;
                end
            end
            S_DRAIN: begin
                // Counter is resetting alongside us; next match starts from zero.
                win_events_d  = '0;
                lose_events_d = '0;
            end
            default: begin
            end
        endcase

        // Pending stop is dropped on IDLE entry and ignored while idle.
        if (state_d == S_IDLE)
            stop_pending_d = 1'b0;
        else if ((state_q != S_IDLE) && stop)
            stop_pending_d = 1'b1;
        else
            stop_pending_d = stop_pending_q;
    end

    // Protocol checks on the counter's outputs; flags stick until start/reset
    always_comb begin
        err_pulse_d   = err_pulse_q;
        err_both_d    = err_both_q;
        err_who_d     = err_who_q;
        prev_winner_d = w_checking && winner;
        prev_loser_d  = w_checking && loser;

        if ((state_q == S_IDLE) && start) begin
            err_pulse_d = 1'b0;
            err_both_d  = 1'b0;
            err_who_d   = 1'b0;
        end

        if (w_checking) begin
            if ((winner && prev_winner_q) || (loser && prev_loser_q))
                err_pulse_d = 1'b1;
            if (winner && loser)
                err_both_d = 1'b1;
            if (w_who_illegal)
                err_who_d = 1'b1;
        end

        // Count-based checks only make sense while events are being counted.
        if (state_q == S_PLAY) begin
            if (gameover && (who == WHO_WIN) && (w_win_eff != GOAL_C))
                err_who_d = 1'b1;
            if (gameover && (who == WHO_LOSE) && (w_lose_eff != GOAL_C))
                err_who_d = 1'b1;
            if (!gameover && winner && (w_win_eff == GOAL_C))
                err_who_d = 1'b1;
            if (!gameover && loser && (w_lose_eff == GOAL_C))
                err_who_d = 1'b1;
        end
    end

    assign control       = control_q;
    assign init          = init_q;
    assign initial_value = initial_value_q;
    assign busy          = busy_q;
    assign win_events    = win_events_q;
    assign lose_events   = lose_events_q;
    assign matches_won   = matches_won_q;
    assign matches_lost  = matches_lost_q;
    assign match_done    = match_done_q;
    assign err_pulse     = err_pulse_q;
    assign err_both      = err_both_q;
    assign err_who       = err_who_q;

endmodule
`default_nettype wire

// File: tb/tb_ctr_game_player.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctr_game_player
//  Description : Self-checking bench for ctr_game_player. Expected output
//                values are queued as stimulus is applied and compared once
//                the clock edge that produces them has passed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ctr_game_player;

    localparam int GOAL    = 15;
    localparam int CNT_W   = 4;
    localparam int MATCH_W = 8;

    localparam int SEL_CONTROL = 0;
    localparam int SEL_INIT    = 1;
    localparam int SEL_IV      = 2;
    localparam int SEL_BUSY    = 3;
    localparam int SEL_WIN     = 4;
    localparam int SEL_LOSE    = 5;
    localparam int SEL_MWON    = 6;
    localparam int SEL_MLOST   = 7;
    localparam int SEL_MDONE   = 8;
    localparam int SEL_EPULSE  = 9;
    localparam int SEL_EBOTH   = 10;
    localparam int SEL_EWHO    = 11;

    logic               clock = 1'b0;
    logic               reset;
    logic               start;
    logic               stop;
    logic               use_init;
    logic [3:0]         start_value;
    logic [1:0]         strategy;
    logic [1:0]         fixed_control;
    logic               winner;
    logic               loser;
    logic               gameover;
    logic [1:0]         who;
    logic [1:0]         control;
    logic               init;
    logic [3:0]         initial_value;
    logic               busy;
    logic [CNT_W-1:0]   win_events;
    logic [CNT_W-1:0]   lose_events;
    logic [MATCH_W-1:0] matches_won;
    logic [MATCH_W-1:0] matches_lost;
    logic               match_done;
    logic               err_pulse;
    logic               err_both;
    logic               err_who;

    ctr_game_player #(.GOAL(GOAL), .CNT_W(CNT_W), .MATCH_W(MATCH_W)) u_dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .use_init      (use_init),
        .start_value   (start_value),
        .strategy      (strategy),
        .fixed_control (fixed_control),
        .winner        (winner),
        .loser         (loser),
        .gameover      (gameover),
        .who           (who),
        .control       (control),
        .init          (init),
        .initial_value (initial_value),
        .busy          (busy),
        .win_events    (win_events),
        .lose_events   (lose_events),
        .matches_won   (matches_won),
        .matches_lost  (matches_lost),
        .match_done    (match_done),
        .err_pulse     (err_pulse),
        .err_both      (err_both),
        .err_who       (err_who)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            SEL_CONTROL: return 32'(control);
            SEL_INIT:    return 32'(init);
            SEL_IV:      return 32'(initial_value);
            SEL_BUSY:    return 32'(busy);
            SEL_WIN:     return 32'(win_events);
            SEL_LOSE:    return 32'(lose_events);
            SEL_MWON:    return 32'(matches_won);
            SEL_MLOST:   return 32'(matches_lost);
            SEL_MDONE:   return 32'(match_done);
            SEL_EPULSE:  return 32'(err_pulse);
            SEL_EBOTH:   return 32'(err_both);
            SEL_EWHO:    return 32'(err_who);
            default:     return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push_exp(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    // Advance one clock, then compare every queued expectation.
    task automatic step();
        exp_t e;
        @(posedge clock);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, sample(e.sel), e.exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; use_init = 1'b0;
        start_value = 4'd0; strategy = 2'd0; fixed_control = 2'd0;
        winner = 1'b0; loser = 1'b0; gameover = 1'b0; who = 2'd0;

        // Reset state: every output low
        step();
        for (int s = 0; s < 12; s++) push_exp("reset_out", s, 32'd0);
        step();

        // Session with init load and up-by-2 strategy
        reset = 1'b0; start = 1'b1; use_init = 1'b1; start_value = 4'd5; strategy = 2'b01;
        push_exp("load_init", SEL_INIT, 1);
        push_exp("load_iv", SEL_IV, 5);
        push_exp("load_busy", SEL_BUSY, 1);
        push_exp("load_ctrl", SEL_CONTROL, 0);
        step();
        start = 1'b0;
        push_exp("play_init", SEL_INIT, 0);
        push_exp("play_iv", SEL_IV, 0);
        push_exp("up2_ctrl", SEL_CONTROL, 1);
        push_exp("play_busy", SEL_BUSY, 1);
        step();
        for (int i = 0; i < 2; i++) begin
            push_exp("up2_ctrl", SEL_CONTROL, 1);
            step();
        end

        // Reset mid-match, then round-robin strategy without init
        reset = 1'b1;
        push_exp("midrst_busy", SEL_BUSY, 0);
        push_exp("midrst_ctrl", SEL_CONTROL, 0);
        step();
        reset = 1'b0; start = 1'b1; use_init = 1'b0; strategy = 2'b11;
        push_exp("rr_load_init", SEL_INIT, 0);
        push_exp("rr_load_iv", SEL_IV, 5);
        push_exp("rr_load_busy", SEL_BUSY, 1);
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_exp("rr_ctrl", SEL_CONTROL, 32'(i % 4));
            step();
        end

        // Fifteen single-cycle winner pulses, gameover on the last
        for (int k = 1; k <= GOAL; k++) begin
            winner = 1'b1;
            if (k == GOAL) begin
                gameover = 1'b1;
                who = 2'b10;
            end
            push_exp("win_cnt", SEL_WIN, 32'(k));
            if (k == GOAL) begin
                push_exp("won_matches", SEL_MWON, 1);
                push_exp("won_done", SEL_MDONE, 1);
                push_exp("drain_ctrl", SEL_CONTROL, 0);
                push_exp("won_errwho", SEL_EWHO, 0);
                push_exp("won_errpulse", SEL_EPULSE, 0);
            end
            step();
            winner = 1'b0; gameover = 1'b0; who = 2'd0;
            if (k < GOAL) begin
                push_exp("win_hold", SEL_WIN, 32'(k));
                push_exp("win_nodone", SEL_MDONE, 0);
                step();
            end
        end
        push_exp("resume_win", SEL_WIN, 0);
        push_exp("resume_done", SEL_MDONE, 0);
        push_exp("resume_busy", SEL_BUSY, 1);
        push_exp("resume_mwon", SEL_MWON, 1);
        step();

        // Protocol violations: simultaneous pulses, then back-to-back winner
        winner = 1'b1; loser = 1'b1;
        push_exp("both_err", SEL_EBOTH, 1);
        push_exp("both_win", SEL_WIN, 1);
        push_exp("both_lose", SEL_LOSE, 1);
        step();
        winner = 1'b0; loser = 1'b0;
        push_exp("both_sticky", SEL_EBOTH, 1);
        push_exp("pulse_clean", SEL_EPULSE, 0);
        step();
        winner = 1'b1;
        push_exp("dbl_win1", SEL_WIN, 2);
        push_exp("pulse_first", SEL_EPULSE, 0);
        step();
        push_exp("dbl_win2", SEL_WIN, 3);
        push_exp("pulse_err", SEL_EPULSE, 1);
        step();
        winner = 1'b0;
        push_exp("both_sticky2", SEL_EBOTH, 1);
        step();

        // Illegal loser gameover at count 3, stop in the same cycle
        loser = 1'b1;
        push_exp("lose_cnt2", SEL_LOSE, 2);
        step();
        loser = 1'b0;
        step();
        loser = 1'b1; gameover = 1'b1; who = 2'b01; stop = 1'b1;
        push_exp("badgo_errwho", SEL_EWHO, 1);
        push_exp("badgo_mlost", SEL_MLOST, 1);
        push_exp("badgo_done", SEL_MDONE, 1);
        push_exp("badgo_lose", SEL_LOSE, 3);
        push_exp("badgo_ctrl", SEL_CONTROL, 0);
        step();
        // start during DRAIN is ignored; session ends in IDLE
        loser = 1'b0; gameover = 1'b0; who = 2'd0; stop = 1'b0;
        start = 1'b1; use_init = 1'b0; strategy = 2'b00; fixed_control = 2'b10;
        push_exp("idle_busy", SEL_BUSY, 0);
        push_exp("idle_eboth", SEL_EBOTH, 1);
        push_exp("idle_epulse", SEL_EPULSE, 1);
        push_exp("idle_ewho", SEL_EWHO, 1);
        push_exp("idle_ctrl", SEL_CONTROL, 0);
        step();
        // start now honoured: flags cleared
        push_exp("restart_busy", SEL_BUSY, 1);
        push_exp("restart_eboth", SEL_EBOTH, 0);
        push_exp("restart_epulse", SEL_EPULSE, 0);
        push_exp("restart_ewho", SEL_EWHO, 0);
        push_exp("restart_init", SEL_INIT, 0);
        push_exp("restart_mlost", SEL_MLOST, 1);
        step();

        // Fixed strategy follows fixed_control live
        start = 1'b0;
        push_exp("fixed_ctrl_a", SEL_CONTROL, 2);
        step();
        fixed_control = 2'b01;
        push_exp("fixed_ctrl_b", SEL_CONTROL, 1);
        step();

        // stop mid-match, start right after is not honoured
        stop = 1'b1;
        push_exp("stop_busy", SEL_BUSY, 1);
        step();
        stop = 1'b0; start = 1'b1;
        push_exp("start_ign_busy", SEL_BUSY, 1);
        push_exp("start_ign_init", SEL_INIT, 0);
        push_exp("start_ign_ctrl", SEL_CONTROL, 1);
        step();
        start = 1'b0;
        for (int k = 1; k <= GOAL; k++) begin
            loser = 1'b1;
            if (k == GOAL) begin
                gameover = 1'b1;
                who = 2'b01;
            end
            push_exp("lose_cnt", SEL_LOSE, 32'(k));
            push_exp("lose_ctrl", SEL_CONTROL, (k == GOAL) ? 32'd0 : 32'd1);
            if (k == GOAL) begin
                push_exp("lost_mlost", SEL_MLOST, 2);
                push_exp("lost_done", SEL_MDONE, 1);
                push_exp("lost_errwho", SEL_EWHO, 0);
                push_exp("lost_mwon", SEL_MWON, 1);
            end
            step();
            loser = 1'b0; gameover = 1'b0; who = 2'd0;
            if (k < GOAL) step();
        end
        push_exp("stopped_busy", SEL_BUSY, 0);
        push_exp("stopped_ctrl", SEL_CONTROL, 0);
        push_exp("stopped_done", SEL_MDONE, 0);
        step();
        stop = 1'b1;
        push_exp("idle_stop_busy", SEL_BUSY, 0);
        step();
        stop = 1'b0;
        push_exp("idle_stay_busy", SEL_BUSY, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ctr_game_player.md
Name: ctr_game_player

Overview:
- Player/referee on the opposite end of the counter-game interface.
- Drives the counter's control code, init strobe and initial value, and consumes its winner/loser/gameover/who outputs.
- Keeps event and match scoreboards and flags protocol violations from the counter.
- Sits beside the counter in the game top level and also serves as the bench-side stimulus/checker for it.

Parameters:
- GOAL, 15, number of win (or lose) events that ends a match; a legal gameover requires the event count to equal GOAL.
- CNT_W, 4, width of the per-match event counters; must satisfy 2^CNT_W-1 >= GOAL.
- MATCH_W, 8, width of the match scoreboards.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin session; honoured in IDLE only
- stop  in  1  end session after the current match
- use_init  in  1  drive init high during LOAD
- start_value  in  4  value presented on initial_value
- strategy  in  2  00 fixed, 01 up-by-2, 10 down-by-2, 11 round-robin
- fixed_control  in  2  control code used when strategy=00
- winner  in  1  counter win pulse
- loser  in  1  counter lose pulse
- gameover  in  1  counter match-end pulse
- who  in  2  01 loser match, 10 winner match
- control  out  2  count code: 00 +1, 01 +2, 10 -1, 11 -2
- init  out  1  load strobe to the counter
- initial_value  out  4  load value to the counter
- busy  out  1  high outside IDLE
- win_events  out  CNT_W  winner pulses in the current match
- lose_events  out  CNT_W  loser pulses in the current match
- matches_won  out  MATCH_W  matches ended with who=10
- matches_lost  out  MATCH_W  matches ended with who=01
- match_done  out  1  one-cycle pulse after a gameover is accepted
- err_pulse  out  1  sticky error flag
- err_both  out  1  sticky error flag
- err_who  out  1  sticky error flag

Behaviour:
- Reset: state IDLE; every output 0; stop_pending=0; round-robin index=0; error flags cleared.
- Outputs are registered.
- States:
  - IDLE: control=00, init=0. start -> LOAD. On the start cycle, capture start_value, use_init and strategy; clear the error flags and event counters.
  - LOAD: one cycle. init=captured use_init; initial_value=captured start_value. Next state PLAY; round-robin index resets to 0.
  - PLAY: control is updated each cycle from the captured strategy.
    - 00: fixed_control, sampled live.
    - 01: constant 01.
    - 10: constant 11.
    - 11: cycles 00,01,10,11 and advances once per PLAY cycle.
    - winner=1: win_events+1. loser=1: lose_events+1. Both counters saturate at 2^CNT_W-1.
    - gameover=1 (this cycle's event already counted, i.e. effective count):
      - who=10: matches_won+1.
      - who=01: matches_lost+1.
      - Match counters wrap.
      - match_done=1 on the next cycle; state -> DRAIN.
  - DRAIN: one cycle, aligned with the counter's own reset cycle. control=00; event counters cleared. Next: stop_pending ? IDLE : PLAY. init is not reasserted; the next match starts from counter value 0.
- Stop and start handling:
  - stop while busy sets stop_pending. It is cleared on IDLE entry.
  - stop in IDLE is ignored.
  - start while busy is ignored.
  - stop and gameover in the same cycle finish the match, then go to IDLE.
- Checks (active in PLAY and DRAIN):
  - err_pulse: winner high on two consecutive cycles, or loser high on two consecutive cycles.
  - err_both: winner and loser high in the same cycle. Both events are still counted.
  - err_who, any of:
    - gameover with who not in {01,10};
    - who=10 with effective win_events != GOAL;
    - who=01 with effective lose_events != GOAL;
    - win_events or lose_events reaching GOAL without gameover in the same cycle.
  - Flags are sticky until reset or an accepted start.
- Inputs are ignored in IDLE and LOAD.
- Reset mid-match: returns to IDLE immediately; scoreboards are lost.

Test Plan:
- reset; start, use_init=1, start_value=5, strategy=01 -> LOAD: init=1, initial_value=5 for exactly one cycle; then control=01 every PLAY cycle; busy=1.
- strategy=11 -> control sequence 00,01,10,11,00 on consecutive PLAY cycles.
- Drive 15 single-cycle winner pulses, with gameover and who=10 on the 15th -> win_events=15; matches_won=1; match_done pulses once; one DRAIN cycle with control=00; PLAY resumes with win_events=0.
- winner and loser high together once -> err_both=1 and stays 1. winner high 2 consecutive cycles -> err_pulse=1. Next start clears both.
- gameover with who=01 while lose_events=3 -> err_who=1; matches_lost=1.
- stop asserted mid-match, then a legal gameover -> DRAIN -> IDLE; busy=0; a start in the cycle after stop is not honoured until IDLE is reached.
